// File: rtl/risc_toy_xalu.sv
// risc_toy_xalu: handshaked, registered execute unit for the RISC_TOY EX stage.
// Single-cycle ALU/address ops load the output register directly; MUL runs an
// iterative shift-add multiplier, one step per cycle, for DW cycles.
module risc_toy_xalu #(
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [4:0]    OP,
  input  logic [DW-1:0] VALA,
  input  logic [DW-1:0] VALB,
  input  logic [21:0]   IMM,
  input  logic          BASE_EN,
  input  logic          FLUSH,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] RESULT,
  output logic          ILLEGAL,
  output logic          BUSY
);

  localparam int unsigned SW = $clog2(DW);
  localparam int unsigned CW = $clog2(DW) + 1;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;
  localparam logic [4:0] OP_MUL  = 5'd24;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] result_q, result_d;
  logic          illegal_q, illegal_d;

  logic [DW-1:0] imm17_c;
  logic [DW-1:0] imm22_c;
  logic [SW-1:0] sh_c;
  logic [DW-1:0] alu_res_c;
  logic          alu_ill_c;
  logic [DW-1:0] acc_step_c;
  logic          accept_c;

  // Sign-extended immediates and shift amount
  assign imm17_c = DW'($signed(IMM[16:0]));
  assign imm22_c = DW'($signed(IMM));
  assign sh_c    = VALB[SW-1:0];

  // Single-cycle result and illegal-opcode decode
  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    case (OP)
      OP_ADDI: alu_res_c = VALB + imm17_c;
      OP_ANDI: alu_res_c = VALB & imm17_c;
      OP_ORI:  alu_res_c = VALB | imm17_c;
      OP_MOVI: alu_res_c = imm17_c;
      OP_ADD:  alu_res_c = VALA + VALB;
      OP_SUB:  alu_res_c = VALA - VALB;
      OP_NEG:  alu_res_c = '0 - VALB;
      OP_NOT:  alu_res_c = ~VALB;
      OP_AND:  alu_res_c = VALA & VALB;
      OP_OR:   alu_res_c = VALA | VALB;
      OP_XOR:  alu_res_c = VALA ^ VALB;
      OP_LSR:  alu_res_c = VALA >> sh_c;
      OP_ASR:  alu_res_c = DW'($signed(VALA) >>> sh_c);
      OP_SHL:  alu_res_c = VALA << sh_c;
      OP_ROR:  alu_res_c = DW'({VALA, VALA} >> sh_c);
      OP_LD,
      OP_ST:   alu_res_c = BASE_EN ? (VALA + imm17_c) : imm17_c;
      OP_LDR,
      OP_STR:  alu_res_c = VALB + imm22_c;
      OP_MUL:  alu_res_c = '0;
      default: alu_ill_c = 1'b1;
    endcase
  end

  // One shift-add multiply step: add multiplicand when multiplier LSB is set
  assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Handshake: accept only when idle, not flushing and output can drain
  assign IN_READY = !FLUSH && (state_q == S_IDLE) && (!out_valid_q || OUT_READY);
  assign accept_c = IN_VALID && IN_READY;

  // Next-state, multiplier datapath and output register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    out_valid_d = out_valid_q && !OUT_READY;
    result_d    = result_q;
    illegal_d   = (out_valid_q && !OUT_READY) ? illegal_q : 1'b0;

    if (FLUSH) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            if (OP == OP_MUL) begin
              acc_d    = '0;
              mcand_d  = VALA;
              mplier_d = VALB;
              cnt_d    = CW'(DW);
              state_d  = S_MUL;
            end else begin
              result_d    = alu_res_c;
              illegal_d   = alu_ill_c;
              out_valid_d = 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_d    = acc_step_c;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d    = acc_step_c;
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign ILLEGAL   = illegal_q;
  assign BUSY      = (state_q == S_MUL);

endmodule

// File: tb/tb_risc_toy_xalu.sv
// Directed testbench for risc_toy_xalu (DW=32 instance plus a DW=8 multiplier check).
module tb_risc_toy_xalu;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;

  logic        in_valid, in_ready, base_en, flush, out_valid, out_ready, illegal, busy;
  logic [4:0]  op;
  logic [31:0] vala, valb, result;
  logic [21:0] imm;

  logic        in_valid8, in_ready8, base_en8, flush8, out_valid8, out_ready8, illegal8, busy8;
  logic [4:0]  op8;
  logic [7:0]  vala8, valb8, result8;
  logic [21:0] imm8;

  int vec  = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  risc_toy_xalu #(.DW(32)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(in_valid), .IN_READY(in_ready), .OP(op),
    .VALA(vala), .VALB(valb), .IMM(imm), .BASE_EN(base_en), .FLUSH(flush),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .RESULT(result),
    .ILLEGAL(illegal), .BUSY(busy)
  );

  risc_toy_xalu #(.DW(8)) u_dut8 (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(in_valid8), .IN_READY(in_ready8), .OP(op8),
    .VALA(vala8), .VALB(valb8), .IMM(imm8), .BASE_EN(base_en8), .FLUSH(flush8),
    .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .RESULT(result8),
    .ILLEGAL(illegal8), .BUSY(busy8)
  );

  task automatic set_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [21:0] im, input logic be);
    op = o; vala = a; valb = b; imm = im; base_en = be;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_op(5'd0, 32'h0, 32'h0, 22'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec++; if (result !== 32'h0) begin errs++; $display("FAIL reset_result: got %h want 0", result); end
    vec++; if (illegal !== 1'b0) begin errs++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_add();
    set_op(5'd4, 32'd5, 32'hFFFF_FFFF, 22'h0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    @(posedge CLK); #1;
    vec++; if (result !== 32'd4) begin errs++; $display("FAIL add_result: got %h want 4", result); end
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
    vec++; if (illegal !== 1'b0) begin errs++; $display("FAIL add_illegal: got %b want 0", illegal); end
    in_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_stream();
    logic [4:0]  ops [3] = '{5'd0, 5'd14, 5'd12};
    logic [31:0] as  [3] = '{32'h0, 32'h8000_0001, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd10, 32'd1, 32'd31};
    logic [21:0] ims [3] = '{22'h1FFFF, 22'h0, 22'h0};
    logic [31:0] exp [3] = '{32'd9, 32'hC000_0000, 32'hFFFF_FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(ops[i], as[i], bs[i], ims[i], 1'b0);
      in_valid = 1'b1;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge CLK); #1;
      vec++; if (result !== exp[i]) begin errs++; $display("FAIL stream_result[%0d]: got %h want %h", i, result, exp[i]); end
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); end
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    set_op(5'd24, 32'h0001_0003, 32'h0000_0005, 22'h0, 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL mul_in_ready_e0: got %b want 0", in_ready); end
    for (int k = 1; k < 32; k++) begin
      @(posedge CLK); #1;
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL mul_busy[%0d]: got %b want 1", k, busy); end
      vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mul_early_valid[%0d]: got %b want 0", k, out_valid); end
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL mul_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    @(posedge CLK); #1;
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL mul_done_valid: got %b want 1", out_valid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mul_done_busy: got %b want 0", busy); end
    vec++; if (result !== 32'h0005_000F) begin errs++; $display("FAIL mul_result: got %h want 0005000f", result); end
    vec++; if (illegal !== 1'b0) begin errs++; $display("FAIL mul_illegal: got %b want 0", illegal); end
    @(posedge CLK); #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mul_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mul8();
    op8 = 5'd24; vala8 = 8'hFF; valb8 = 8'hFF; out_ready8 = 1'b1; in_valid8 = 1'b1;
    @(posedge CLK); #1;
    in_valid8 = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge CLK); #1;
      vec++; if (out_valid8 !== 1'b0) begin errs++; $display("FAIL mul8_early_valid[%0d]: got %b want 0", k, out_valid8); end
      vec++; if (busy8 !== 1'b1) begin errs++; $display("FAIL mul8_busy[%0d]: got %b want 1", k, busy8); end
    end
    @(posedge CLK); #1;
    vec++; if (out_valid8 !== 1'b1) begin errs++; $display("FAIL mul8_valid: got %b want 1", out_valid8); end
    vec++; if (result8 !== 8'h01) begin errs++; $display("FAIL mul8_result: got %h want 01", result8); end
    vec++; if (busy8 !== 1'b0) begin errs++; $display("FAIL mul8_busy_done: got %b want 0", busy8); end
    @(posedge CLK); #1;
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    set_op(5'd3, 32'h0, 32'h0, 22'h01234, 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    vec++; if (result !== 32'h1234) begin errs++; $display("FAIL stall_first: got %h want 1234", result); end
    out_ready = 1'b0;
    set_op(5'd5, 32'd3, 32'd7, 22'h0, 1'b0);
    #1;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_in_ready_0: got %b want 0", in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      vec++; if (result !== 32'h1234) begin errs++; $display("FAIL stall_hold[%0d]: got %h want 1234", k, result); end
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    @(posedge CLK); #1;
    vec++; if (result !== 32'hFFFF_FFFC) begin errs++; $display("FAIL stall_sub: got %h want fffffffc", result); end
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_sub_valid: got %b want 1", out_valid); end
    in_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_flush();
    logic saw;
    out_ready = 1'b1;
    set_op(5'd24, 32'h1234, 32'h5678, 22'h0, 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    flush = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge CLK); #1;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy: got %b want 0", busy); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    vec++; if (result !== 32'hFFFF_FFFC) begin errs++; $display("FAIL flush_result_kept: got %h want fffffffc", result); end
    flush = 1'b0;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
    saw = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (out_valid) saw = 1'b1;
    end
    vec++; if (saw !== 1'b0) begin errs++; $display("FAIL flush_stale_valid: got %b want 0", saw); end
  endtask

  task automatic test_flush_final();
    out_ready = 1'b1;
    set_op(5'd24, 32'd3, 32'd3, 22'h0, 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (31) @(posedge CLK);
    #1;
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL flushfin_busy_pre: got %b want 1", busy); end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flushfin_valid: got %b want 0", out_valid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL flushfin_busy: got %b want 0", busy); end
    vec++; if (result !== 32'hFFFF_FFFC) begin errs++; $display("FAIL flushfin_result: got %h want fffffffc", result); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_mul();
    logic saw;
    out_ready = 1'b1;
    set_op(5'd24, 32'd7, 32'd9, 22'h0, 1'b0);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RSTN = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    vec++; if (result !== 32'h0) begin errs++; $display("FAIL rst_mid_result: got %h want 0", result); end
    vec++; if (illegal !== 1'b0) begin errs++; $display("FAIL rst_mid_illegal: got %b want 0", illegal); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    @(negedge CLK);
    RSTN = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (out_valid) saw = 1'b1;
    end
    vec++; if (saw !== 1'b0) begin errs++; $display("FAIL rst_mid_stale: got %b want 0", saw); end
    vec++; if (result !== 32'h0) begin errs++; $display("FAIL rst_mid_result_after: got %h want 0", result); end
  endtask

  task automatic test_illegal_addr();
    logic [4:0]  ops [6] = '{5'd17, 5'd31, 5'd19, 5'd20, 5'd21, 5'd14};
    logic [31:0] as  [6] = '{32'h55, 32'h66, 32'h999, 32'h0, 32'h1000, 32'hDEAD_BEEF};
    logic [31:0] bs  [6] = '{32'h77, 32'h88, 32'h0, 32'h100, 32'h0, 32'h20};
    logic [21:0] ims [6] = '{22'h0, 22'h0, 22'h00010, 22'h3FFFFC, 22'h1FFFF, 22'h0};
    logic        bes [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp [6] = '{32'h0, 32'h0, 32'h10, 32'hFC, 32'hFFF, 32'hDEAD_BEEF};
    logic        eil [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_op(ops[i], as[i], bs[i], ims[i], bes[i]);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      vec++; if (result !== exp[i]) begin errs++; $display("FAIL op%0d_result: got %h want %h", ops[i], result, exp[i]); end
      vec++; if (illegal !== eil[i]) begin errs++; $display("FAIL op%0d_illegal: got %b want %b", ops[i], illegal, eil[i]); end
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL op%0d_valid: got %b want 1", ops[i], out_valid); end
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    in_valid8 = 1'b0; op8 = 5'd0; vala8 = 8'h0; valb8 = 8'h0; imm8 = 22'h0;
    base_en8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b1;
    test_reset();
    test_add();
    test_stream();
    test_mul();
    test_mul8();
    test_stall();
    test_flush();
    test_flush_final();
    test_reset_mid_mul();
    test_illegal_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/risc_toy_xalu.md
# risc_toy_xalu

Parametrised, handshaked execute unit for the RISC_TOY EX stage. It replaces the purely combinational ALU with a registered result stage. It adds width parametrisation, a multi-cycle shift-add multiplier, a flush input and an illegal-opcode flag. It sits between the ID_EX and EX_MEM pipeline registers; the pipeline control holds ID_EX while IN_READY is low.

## Interface
Parameters:
- DW, 32, datapath width; power of two, 8..64.
- SW, log2(DW), shift-amount width (derived, not overridable).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operation offered.
- IN_READY  out  1  unit accepts operation this cycle.
- OP  in  5  RISC_TOY opcode.
- VALA  in  DW  first source value.
- VALB  in  DW  second source value; PC for LDR/STR.
- IMM  in  22  raw immediate field.
- BASE_EN  in  1  LD/ST use base register (rb != 0).
- FLUSH  in  1  synchronous kill of in-flight/held operation.
- OUT_VALID  out  1  RESULT valid.
- OUT_READY  in  1  downstream consumes RESULT.
- RESULT  out  DW  registered result.
- ILLEGAL  out  1  registered; high with OUT_VALID for an undefined OP.
- BUSY  out  1  multiplier iterating.

## Operation
- IMM17 = IMM[16:0] sign-extended to DW; IMM22 = IMM[21:0] sign-extended to DW (truncated if DW < 22).
- Single-cycle ops:
  - ADDI/ANDI/ORI (0,1,2): VALB op IMM17.
  - MOVI (3): IMM17.
  - ADD/SUB (4,5): VALA ± VALB.
  - NEG (6): -VALB.
  - NOT (7): ~VALB.
  - AND/OR/XOR (8,9,10): VALA op VALB.
- Shifts use sh = VALB[SW-1:0]:
  - LSR (11): logical right.
  - ASR (12): arithmetic right.
  - SHL (13): left.
  - ROR (14): rotate right; sh=0 returns VALA unchanged.
- Address ops:
  - LD/ST (19,21): BASE_EN ? VALA+IMM17 : IMM17.
  - LDR/STR (20,22): VALB+IMM22.
- MUL (24): low DW bits of unsigned VALA×VALB, one shift-add step per cycle, DW steps.
- All arithmetic is modulo 2^DW; no overflow or carry outputs.
- Any other OP, including 15–18 (branches/jumps, not handled here): RESULT=0, ILLEGAL=1, single-cycle.
- FSM states:
  - IDLE: accept when IN_VALID && IN_READY. A single-cycle op goes straight to the output register. MUL latches operands, loads the step counter with DW, and goes to MUL.
  - MUL: one step per cycle, counter decrements. When the counter reaches 1, the final step writes the output register and the FSM returns to IDLE.
- Output register:
  - Loads on completion.
  - Holds RESULT/ILLEGAL stable while OUT_VALID && !OUT_READY.
  - OUT_VALID clears on the handshake unless a new result loads in the same edge.
- IN_READY = !FLUSH && state==IDLE && (!OUT_VALID || OUT_READY). It is combinational; IN_VALID must not depend on it.
- BUSY = (state==MUL).
- FLUSH (priority over everything except reset):
  - Next edge: state←IDLE, OUT_VALID←0, ILLEGAL←0, counter←0.
  - RESULT is left unchanged.
  - No operation is accepted in a FLUSH cycle.

## Timing
- Reset values:
  - Registered outputs: OUT_VALID=0, RESULT=0, ILLEGAL=0, BUSY=0, state=IDLE.
  - IN_READY is combinational: it reads 1 when FLUSH=0 and reset state (state=IDLE, OUT_VALID=0) holds.
- Single-cycle op accepted at edge E: OUT_VALID=1 after E. Throughput is 1/cycle with OUT_READY=1.
- MUL accepted at edge E: BUSY=1 during E+1..E+DW-1; OUT_VALID=1 and BUSY=0 after edge E+DW. IN_READY=0 throughout.
- Back-to-back: when OUT_VALID=1 and OUT_READY=1, a new single-cycle op accepted at the same edge replaces RESULT, and OUT_VALID stays 1.
- Downstream stall: when OUT_VALID=1 and OUT_READY=0, IN_READY=0. An in-progress MUL cannot start in this condition (it is gated at acceptance).
- Reset asserted mid-MUL: immediate return to reset values; no stale result appears after RSTN deasserts.
- FLUSH and the MUL final step in the same cycle: FLUSH wins, and no result is produced.

## Test plan
- Reset, then ADD VALA=5, VALB=0xFFFFFFFF, OUT_READY=1 -> RESULT=4 after one edge; ILLEGAL=0.
- Stream ADDI(VALB=10, IMM=0x1FFFF), ROR(VALA=0x80000001, VALB=1), ASR(VALA=0x80000000, VALB=31) on consecutive cycles -> RESULT 9, 0xC0000000, 0xFFFFFFFF on three consecutive cycles; IN_READY constantly 1.
- MUL VALA=0x0001_0003, VALB=0x0000_0005 -> BUSY for 31 cycles, OUT_VALID exactly 32 edges after acceptance, RESULT=0x0005_000F. Repeat with DW=8: 0xFF×0xFF -> 0x01 after 8 edges.
- Hold OUT_READY=0 for 5 cycles after a result of 0x1234 -> RESULT/OUT_VALID stable, IN_READY=0 throughout. Raising OUT_READY with IN_VALID=1 (SUB 3-7) -> next RESULT=0xFFFFFFFC.
- Assert FLUSH during MUL cycle 10 -> OUT_VALID never rises for it, BUSY=0 next cycle, IN_READY=1 the cycle after FLUSH drops. Repeat with RSTN pulsed low mid-MUL -> all outputs at reset values.
- OP=17 (J) and OP=31 -> ILLEGAL=1, RESULT=0. LD with BASE_EN=0, IMM=0x00010 -> RESULT=0x10. LDR with VALB=0x100, IMM=0x3FFFFC -> RESULT=0xFC.
